alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_if.sv | 29 ++
 rtl/alu_pipe.sv | 184 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Request/response bundle for alu_pipe.
// Master drives requests and consumes results; slave is the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y;
    logic             Zero;
    logic             Cout;
    logic             Borrow;
    logic             Overflow;
    logic             busy;

    modport master (
        output in_valid, A, B, sel, out_ready,
        input  in_ready, out_valid, Y, Zero, Cout, Borrow, Overflow, busy
    );

    modport slave (
        input  in_valid, A, B, sel, out_ready,
        output in_ready, out_valid, Y, Zero, Cout, Borrow, Overflow, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU with an optional iterative shift-add multiplier.
// Stage 1 holds the operands; stage 2 is the result/flag register.
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input logic      Clock,
    input logic      Reset_n,
    alu_pipe_if.slave bus
);
    localparam int M  = WIDTH - 1;
    localparam int SH = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_INC  = 4'd5;
    localparam logic [3:0] OP_DEC  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_sel;

    logic [1:0]         state;
    logic [SH-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;

    logic s1_mul;
    logic s2_free;
    logic s1_adv;
    logic accept;
    logic mul_acc;

    assign s1_mul  = s1_valid && (MUL_EN != 0) && (s1_sel == OP_MUL);
    assign s2_free = !bus.out_valid || bus.out_ready;
    assign s1_adv  = s1_valid && s2_free && (!s1_mul || state == DONE);
    assign accept  = bus.in_valid && bus.in_ready;
    assign mul_acc = accept && (MUL_EN != 0) && (bus.sel == OP_MUL);

    assign bus.busy     = (MUL_EN != 0) && (state != IDLE);
    assign bus.in_ready = !bus.busy && (!s1_valid || s1_adv);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sel   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.A;
            s1_b     <= bus.B;
            s1_sel   <= bus.sel;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // One shift-add step: add the multiplicand into the high half, shift right.
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   hi_sum;

    assign addend = acc[0] ? s1_a : '0;
    assign hi_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_acc) begin
                        state <= RUN;
                        cnt   <= SH'(WIDTH - 1);
                        acc   <= {{WIDTH{1'b0}}, bus.B};
                    end
                end
                RUN: begin
                    acc <= {hi_sum, acc[WIDTH-1:1]};
                    if (cnt == '0) state <= DONE;
                    else           cnt   <= cnt - 1'b1;
                end
                DONE: begin
                    if (s1_adv) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   inc;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] dec;
    logic [SH-1:0]    sh;
    logic [WIDTH-1:0] r_y;
    logic             r_c;
    logic             r_b;
    logic             r_v;

    always_comb begin
        sum  = {1'b0, s1_a} + {1'b0, s1_b};
        inc  = {1'b0, s1_a} + {{WIDTH{1'b0}}, 1'b1};
        diff = s1_a - s1_b;
        dec  = s1_a - {{M{1'b0}}, 1'b1};
        sh   = s1_b[SH-1:0];
        r_y  = '0;
        r_c  = 1'b0;
        r_b  = 1'b0;
        r_v  = 1'b0;
        case (s1_sel)
            OP_ADD: begin
                r_y = sum[WIDTH-1:0];
                r_c = sum[WIDTH];
                r_v = (s1_a[M] == s1_b[M]) && (sum[M] != s1_a[M]);
            end
            OP_SUB: begin
                r_y = diff;
                r_b = s1_a < s1_b;
                r_v = (s1_a[M] != s1_b[M]) && (diff[M] != s1_a[M]);
            end
            OP_AND: r_y = s1_a & s1_b;
            OP_OR:  r_y = s1_a | s1_b;
            OP_XOR: r_y = s1_a ^ s1_b;
            OP_INC: begin
                r_y = inc[WIDTH-1:0];
                r_c = inc[WIDTH];
                r_v = !s1_a[M] && inc[M];
            end
            OP_DEC: begin
                r_y = dec;
                r_b = (s1_a == '0);
                r_v = s1_a[M] && !dec[M];
            end
            OP_SLL:  r_y = s1_a << sh;
            OP_SRL:  r_y = s1_a >> sh;
            OP_SRA:  r_y = $unsigned($signed(s1_a) >>> sh);
            OP_SLT:  r_y = {{M{1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            OP_SLTU: r_y = {{M{1'b0}}, (s1_a < s1_b)};
            OP_MUL: begin
                if (MUL_EN != 0) begin
                    r_y = acc[WIDTH-1:0];
                    r_c = |acc[2*WIDTH-1:WIDTH];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.out_valid <= 1'b0;
            bus.Y         <= '0;
            bus.Zero      <= 1'b0;
            bus.Cout      <= 1'b0;
            bus.Borrow    <= 1'b0;
            bus.Overflow  <= 1'b0;
        end else if (s1_adv) begin
            bus.out_valid <= 1'b1;
            bus.Y         <= r_y;
            bus.Zero      <= (r_y == '0);
            bus.Cout      <= r_c;
            bus.Borrow    <= r_b;
            bus.Overflow  <= r_v;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed checks of alu_pipe against an arithmetic model.
// Every in-flight result is tracked in a FIFO and checked at negedge.
module tb_alu_pipe;
    typedef struct packed {
        logic [31:0] y;
        logic        z;
        logic        c;
        logic        b;
        logic        v;
    } res_t;

    logic Clock;
    logic Reset_n;
    int   n_chk;
    int   n_fail;

    alu_pipe_if #(.WIDTH(32)) bus ();

    alu_pipe #(
        .WIDTH (32),
        .MUL_EN(1)
    ) dut (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic [3:0] s);
        res_t              r;
        int                ia;
        int                ib;
        longint            sa;
        longint            sb;
        longint            t;
        longint unsigned   ua;
        longint unsigned   ub;
        longint unsigned   w;
        r  = '0;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        ua = a;
        ub = b;
        t  = 0;
        case (s)
            4'd0: begin
                w = ua + ub; r.y = w[31:0]; r.c = w[32];
                t = sa + sb;
            end
            4'd1: begin
                r.y = a - b; r.b = (ua < ub);
                t = sa - sb;
            end
            4'd2: r.y = a & b;
            4'd3: r.y = a | b;
            4'd4: r.y = a ^ b;
            4'd5: begin
                w = ua + 1; r.y = w[31:0]; r.c = w[32];
                t = sa + 1;
            end
            4'd6: begin
                r.y = a - 1; r.b = (a == 0);
                t = sa - 1;
            end
            4'd7: r.y = a << b[4:0];
            4'd8: r.y = a >> b[4:0];
            4'd9: r.y = $unsigned(ia >>> b[4:0]);
            4'd10: r.y = (ia < ib) ? 32'd1 : 32'd0;
            4'd11: r.y = (a < b) ? 32'd1 : 32'd0;
            4'd12: begin
                w = ua * ub; r.y = w[31:0];
                r.c = ((w >> 32) != 0);
            end
            default: ;
        endcase
        if (s <= 4'd1 || s == 4'd5 || s == 4'd6)
            r.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        r.z = (r.y == 0);
        return r;
    endfunction

    res_t        q[$];
    logic [31:0] cons_y[$];
    logic        stalled;
    res_t        held;

    always @(negedge Clock) begin
        res_t got;
        got = {bus.Y, bus.Zero, bus.Cout, bus.Borrow, bus.Overflow};
        if (!Reset_n) begin
            q.delete();
            stalled = 1'b0;
        end else begin
            if (bus.busy) chk("busy_blocks_ready", 64'(bus.in_ready), 0);
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got Y=%0h expected none",
                             bus.Y);
                end else begin
                    chk("result", 64'(got), 64'(q[0]));
                end
                if (stalled) chk("stall_hold", 64'(got), 64'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                cons_y.push_back(bus.Y);
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = got;
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.A, bus.B, bus.sel));
        end
    end

    task automatic push_op(input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] s);
        bus.A        = a;
        bus.B        = b;
        bus.sel      = s;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            if (bus.in_ready) begin
                @(posedge Clock);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        chk("accept_timeout", 1, 0);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] s, output res_t r,
                         output int lat, output int busy_n,
                         output int rdy_n);
        bus.out_ready = 1'b1;
        push_op(a, b, s);
        lat    = 0;
        busy_n = 0;
        rdy_n  = 0;
        while (lat < 100) begin
            @(negedge Clock);
            lat++;
            if (bus.out_valid) break;
            if (bus.busy) busy_n++;
            if (bus.in_ready) rdy_n++;
        end
        if (!bus.out_valid) chk("result_timeout", 0, 1);
        r = {bus.Y, bus.Zero, bus.Cout, bus.Borrow, bus.Overflow};
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        res_t r;
        int   lat;
        int   bn;
        int   rn;
        int   base;
        int   seen;
        int   sent;
        int   cyc;
        logic acc;

        n_chk         = 0;
        n_fail        = 0;
        Reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.sel       = '0;
        bus.out_ready = 1'b0;

        r = model(32'hFFFF_FFFF, 32'h1, 4'd0);
        chk("model_add", 64'(r), 64'({32'h0, 4'b1100}));
        r = model(32'h8000_0000, 32'h1, 4'd1);
        chk("model_sub", 64'(r), 64'({32'h7FFF_FFFF, 4'b0001}));
        r = model(32'h0001_0000, 32'h0001_0000, 4'd12);
        chk("model_mul", 64'(r), 64'({32'h0, 4'b1100}));

        repeat (3) @(posedge Clock);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_y", 64'(bus.Y), 0);
        chk("rst_flags", 64'({bus.Zero, bus.Cout, bus.Borrow, bus.Overflow}), 0);
        chk("rst_busy", 64'(bus.busy), 0);
        Reset_n = 1'b1;
        @(negedge Clock);
        chk("rdy_after_rst", 64'(bus.in_ready), 1);
        @(posedge Clock);
        #1;

        do_op(32'hFFFF_FFFF, 32'h1, 4'd0, r, lat, bn, rn);
        chk("add_wrap", 64'(r), 64'({32'h0, 4'b1100}));
        chk("add_latency", 64'(lat), 2);

        do_op(32'h8000_0000, 32'h1, 4'd1, r, lat, bn, rn);
        chk("sub_ovf", 64'(r), 64'({32'h7FFF_FFFF, 4'b0001}));
        do_op(32'h0, 32'h0, 4'd6, r, lat, bn, rn);
        chk("dec_zero", 64'(r), 64'({32'hFFFF_FFFF, 4'b0010}));
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd14, r, lat, bn, rn);
        chk("reserved", 64'(r), 64'({32'h0, 4'b1000}));
        do_op(32'hFFFF_FFFF, 32'h1, 4'd10, r, lat, bn, rn);
        chk("slt", 64'(r.y), 1);
        do_op(32'hFFFF_FFFF, 32'h1, 4'd11, r, lat, bn, rn);
        chk("sltu", 64'(r.y), 0);
        do_op(32'h1234_5678, 32'h0, 4'd7, r, lat, bn, rn);
        chk("sll_zero", 64'(r.y), 64'h1234_5678);

        do_op(32'h0001_0000, 32'h0001_0000, 4'd12, r, lat, bn, rn);
        chk("mul_res", 64'(r), 64'({32'h0, 4'b1100}));
        chk("mul_latency", 64'(lat), 34);
        chk("mul_busy_cycles", 64'(bn), 33);
        chk("mul_ready_low", 64'(rn), 0);

        // Fill both stages under backpressure, then release in order.
        base          = cons_y.size();
        bus.out_ready = 1'b0;
        push_op(32'h1, 32'h2, 4'd0);
        push_op(32'hF0F0_0000, 32'h0FF0_0000, 4'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk("full_not_ready", 64'(bus.in_ready), 0);
            chk("full_valid", 64'(bus.out_valid), 1);
        end
        @(posedge Clock);
        #1;
        bus.out_ready = 1'b1;
        push_op(32'h8000_0000, 32'h4, 4'd9);
        for (int i = 0; i < 20 && cons_y.size() < base + 3; i++)
            @(negedge Clock);
        chk("bp_count", 64'(cons_y.size() - base), 3);
        if (cons_y.size() >= base + 3) begin
            chk("bp_y0", 64'(cons_y[base]), 64'h3);
            chk("bp_y1", 64'(cons_y[base+1]), 64'hFF00_0000);
            chk("bp_y2", 64'(cons_y[base+2]), 64'hF800_0000);
        end
        @(posedge Clock);
        #1;

        push_op(32'h0000_0003, 32'h0000_0005, 4'd12);
        repeat (10) @(posedge Clock);
        #1;
        chk("mid_mul_busy", 64'(bus.busy), 1);
        Reset_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 0);
        chk("abort_y", 64'(bus.Y), 0);
        chk("abort_flags",
            64'({bus.Zero, bus.Cout, bus.Borrow, bus.Overflow}), 0);
        chk("abort_busy", 64'(bus.busy), 0);
        repeat (2) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        @(negedge Clock);
        chk("rdy_after_abort", 64'(bus.in_ready), 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (bus.out_valid) seen++;
        end
        chk("no_out_after_abort", 64'(seen), 0);
        @(posedge Clock);
        #1;
        do_op(32'h2, 32'h3, 4'd0, r, lat, bn, rn);
        chk("add_after_abort", 64'(r.y), 5);

        sent = 0;
        cyc  = 0;
        while (sent < 300 && cyc < 20000) begin
            @(negedge Clock);
            acc = bus.in_valid && bus.in_ready;
            @(posedge Clock);
            #1;
            cyc++;
            if (acc) sent++;
            if (acc || !bus.in_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus.A        = pick();
                    bus.B        = pick();
                    bus.sel      = ($urandom_range(0, 9) == 0) ? 4'd12 :
                                   4'($urandom_range(0, 15));
                    bus.in_valid = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.in_valid = 1'b0;
        chk("rand_all_sent", 64'(sent), 300);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200 && q.size() > 0; i++)
            @(negedge Clock);
        chk("drain_empty", 64'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
